serial_sub_32bit: RTL

Digit-serial 32-bit subtractor with borrow-in and borrow-out. It computes diff = a − b − bin over several clock cycles and reports completion with a start/done handshake. It is the inverse-direction companion to the team's 32-bit carry-lookahead adder. It targets area-constrained datapaths where a full-width borrow chain is not affordable, and it shares the adder's operand and flag conventions (a, b, 32-bit result, carry/borrow bit).

---
 rtl/serial_sub_32bit.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/serial_sub_32bit.sv
// Digit-serial 32-bit subtractor: diff = a - b - bin, DIGIT_W bits per cycle, start/done handshake.
// Define SUB_OVF_EN to enable the signed overflow flag; otherwise ovf is tied to 0.
module serial_sub_32bit #(
  parameter int unsigned DIGIT_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        bin,
  output logic        busy,
  output logic        done,
  output logic [31:0] diff,
  output logic        bout,
  output logic        ovf
);

  localparam int unsigned NumDigits = 32 / DIGIT_W;

  if (DIGIT_W < 1 || DIGIT_W > 32 || (32 % DIGIT_W) != 0) begin : g_bad_digit_w
    $error("serial_sub_32bit: DIGIT_W must be one of 1, 2, 4, 8, 16, 32");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e        state_q, state_d;
  logic [31:0]   a_sh_q, a_sh_d;
  logic [31:0]   b_sh_q, b_sh_d;
  logic [31:0]   diff_sh_q, diff_sh_d;
  logic          borrow_q, borrow_d;
  logic [5:0]    cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [31:0]   diff_q, diff_d;
  logic          bout_q, bout_d;

  logic [DIGIT_W-1:0]  a_dig, b_dig;
  logic [DIGIT_W:0]    dig_res;
  logic [31+DIGIT_W:0] diff_cat;
  logic                last_dig;

  assign a_dig = a_sh_q[DIGIT_W-1:0];
  assign b_dig = b_sh_q[DIGIT_W-1:0];
  // The extra MSB of the widened difference is the borrow out of this digit.
  assign dig_res = {1'b0, a_dig} - {1'b0, b_dig} - {{DIGIT_W{1'b0}}, borrow_q};
  assign diff_cat = {dig_res[DIGIT_W-1:0], diff_sh_q};
  assign last_dig = (cnt_q == 6'(NumDigits - 1));

`ifdef SUB_OVF_EN
  logic a_sign_q, a_sign_d;
  logic b_sign_q, b_sign_d;
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    diff_sh_d = diff_sh_q;
    borrow_d  = borrow_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    diff_d    = diff_q;
    bout_d    = bout_q;
`ifdef SUB_OVF_EN
    a_sign_d  = a_sign_q;
    b_sign_d  = b_sign_q;
    ovf_d     = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StRun;
          a_sh_d   = a;
          b_sh_d   = b;
          borrow_d = bin;
          cnt_d    = '0;
          busy_d   = 1'b1;
`ifdef SUB_OVF_EN
          a_sign_d = a[31];
          b_sign_d = b[31];
`endif
        end
      end
      StRun: begin
        a_sh_d    = a_sh_q >> DIGIT_W;
        b_sh_d    = b_sh_q >> DIGIT_W;
        diff_sh_d = diff_cat[31+DIGIT_W:DIGIT_W];
        borrow_d  = dig_res[DIGIT_W];
        cnt_d     = cnt_q + 6'd1;
        if (last_dig) begin
          state_d = StDone;
          done_d  = 1'b1;
          diff_d  = diff_sh_d;
          bout_d  = borrow_d;
`ifdef SUB_OVF_EN
          ovf_d   = (a_sign_q != b_sign_q) && (diff_sh_d[31] != a_sign_q);
`endif
        end
      end
      StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      diff_sh_q <= '0;
      borrow_q  <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      diff_q    <= '0;
      bout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      diff_sh_q <= diff_sh_d;
      borrow_q  <= borrow_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      diff_q    <= diff_d;
      bout_q    <= bout_d;
    end
  end

`ifdef SUB_OVF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sign_q <= 1'b0;
      b_sign_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      a_sign_q <= a_sign_d;
      b_sign_q <= b_sign_d;
      ovf_q    <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule
